// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces a one-hot keypad, accepts one digit per press
// and assembles NUM_DIGITS BCD digits that are committed with enter.
module keypad_entry_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 70
) (
  input  logic                    i_clk,
  input  logic                    i_clear,
  input  logic [9:0]              i_keypad,
  input  logic                    i_enter,
  input  logic                    i_cancel,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic [2:0]              o_digit_count,
  output logic                    o_key_valid,
  output logic                    o_code_ready,
  output logic                    o_timeout,
  output logic                    o_multi_key_err,
  output logic                    o_busy
);

  localparam int DW  = 4 * NUM_DIGITS;
  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  function automatic logic [3:0] onehot_to_bcd(input logic [9:0] oh);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      code = oh[i] ? 4'(i) : code;
    end
    return code;
  endfunction

  state_t           r_state;
  logic [9:0]       r_pattern;
  logic [SCW-1:0]   r_stable_cnt;
  logic [TCW-1:0]   r_to_cnt;
  logic [DW-1:0]    r_digits;
  logic [2:0]       r_count;
  logic             r_key_valid;
  logic             r_code_ready;
  logic             r_timeout;
  logic             r_multi_err;
  logic             r_busy;

  state_t           w_state_nxt;
  state_t           w_state_fin;
  logic [9:0]       w_pattern_nxt;
  logic [SCW-1:0]   w_stable_nxt;
  logic [SCW-1:0]   w_stable_inc;
  logic             w_accept;
  logic             w_multi;
  logic             w_none;
  logic             w_single;
  logic             w_full;
  logic [3:0]       w_code;
  logic [TCW-1:0]   w_to_inc;
  logic [TCW-1:0]   w_to_nxt;
  logic [DW-1:0]    w_digits_nxt;
  logic [2:0]       w_count_nxt;
  logic             w_kv_nxt;
  logic             w_cr_nxt;
  logic             w_to_pulse_nxt;
  logic             w_mk_nxt;

  assign w_none       = (i_keypad == 10'd0);
  assign w_single     = !w_none && ((i_keypad & (i_keypad - 10'd1)) == 10'd0);
  assign w_full       = (r_count == 3'(NUM_DIGITS));
  assign w_stable_inc = r_stable_cnt + SCW'(1);
  assign w_to_inc     = r_to_cnt + TCW'(1);
  // An accepted key always matches the live keypad, so encode it directly.
  assign w_code       = onehot_to_bcd(i_keypad);

  // Keypad FSM: debounce, single-digit acceptance and hold-until-release.
  always_comb begin
    w_state_nxt   = r_state;
    w_pattern_nxt = r_pattern;
    w_stable_nxt  = r_stable_cnt;
    w_accept      = 1'b0;
    w_multi       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_none) begin
          w_state_nxt = ST_IDLE;
        end else if (w_single) begin
          w_pattern_nxt = i_keypad;
          w_stable_nxt  = SCW'(1);
          if (STABLE_CYCLES == 1) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_DEBOUNCE;
          end
        end else begin
          w_multi     = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_DEBOUNCE: begin
        if (i_keypad == r_pattern) begin
          w_stable_nxt = w_stable_inc;
          if (w_stable_inc == SCW'(STABLE_CYCLES)) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_DEBOUNCE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (w_none) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Entry buffer, pulses and inactivity counter; cancel > enter > key > timeout.
  always_comb begin
    w_state_fin    = w_state_nxt;
    w_digits_nxt   = r_digits;
    w_count_nxt    = r_count;
    w_to_nxt       = r_to_cnt;
    w_kv_nxt       = 1'b0;
    w_cr_nxt       = 1'b0;
    w_to_pulse_nxt = 1'b0;
    w_mk_nxt       = 1'b0;
    if (i_cancel) begin
      w_digits_nxt = '0;
      w_count_nxt  = 3'd0;
      w_to_nxt     = '0;
      w_state_fin  = w_none ? ST_IDLE : ST_HOLD;
    end else begin
      w_mk_nxt = w_multi;
      if (i_enter && w_full) begin
        // A key accepted on the commit edge is dropped; the FSM already heads to HOLD.
        w_cr_nxt    = 1'b1;
        w_count_nxt = 3'd0;
        w_to_nxt    = '0;
      end else if (w_accept && !w_full) begin
        w_digits_nxt = (r_count == 3'd0) ? DW'(w_code) : ((r_digits << 4) | DW'(w_code));
        w_count_nxt  = r_count + 3'd1;
        w_kv_nxt     = 1'b1;
        w_to_nxt     = '0;
      end else if (r_state != ST_IDLE) begin
        w_to_nxt = '0;
      end else if ((r_count != 3'd0) && !w_full) begin
        if (w_to_inc == TCW'(TIMEOUT_CYCLES)) begin
          w_to_pulse_nxt = 1'b1;
          w_digits_nxt   = '0;
          w_count_nxt    = 3'd0;
          w_to_nxt       = '0;
        end else begin
          w_to_nxt = w_to_inc;
        end
      end else begin
        w_to_nxt = '0;
      end
    end
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_state      <= ST_IDLE;
      r_pattern    <= 10'd0;
      r_stable_cnt <= '0;
      r_to_cnt     <= '0;
      r_digits     <= '0;
      r_count      <= 3'd0;
      r_key_valid  <= 1'b0;
      r_code_ready <= 1'b0;
      r_timeout    <= 1'b0;
      r_multi_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_fin;
      r_pattern    <= w_pattern_nxt;
      r_stable_cnt <= w_stable_nxt;
      r_to_cnt     <= w_to_nxt;
      r_digits     <= w_digits_nxt;
      r_count      <= w_count_nxt;
      r_key_valid  <= w_kv_nxt;
      r_code_ready <= w_cr_nxt;
      r_timeout    <= w_to_pulse_nxt;
      r_multi_err  <= w_mk_nxt;
      r_busy       <= (w_state_fin != ST_IDLE);
    end
  end

  assign o_digits        = r_digits;
  assign o_digit_count   = r_count;
  assign o_key_valid     = r_key_valid;
  assign o_code_ready    = r_code_ready;
  assign o_timeout       = r_timeout;
  assign o_multi_key_err = r_multi_err;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl: press tables plus hand-written corner sequences,
// with a digit scoreboard popped on every key_valid pulse.
module tb_keypad_entry_ctrl;

  localparam int ND = 4;
  localparam int SC = 3;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          clear;
  logic [9:0]    keypad;
  logic          enter;
  logic          cancel;
  logic [15:0]   o_digits;
  logic [2:0]    o_digit_count;
  logic          o_key_valid;
  logic          o_code_ready;
  logic          o_timeout;
  logic          o_multi_key_err;
  logic          o_busy;

  always #5 clk = ~clk;

  keypad_entry_ctrl #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_clear(clear), .i_keypad(keypad), .i_enter(enter), .i_cancel(cancel),
    .o_digits(o_digits), .o_digit_count(o_digit_count), .o_key_valid(o_key_valid),
    .o_code_ready(o_code_ready), .o_timeout(o_timeout), .o_multi_key_err(o_multi_key_err),
    .o_busy(o_busy)
  );

  typedef struct {
    int          key;
    int          hold;
    int          gap;
    bit          accept;
    logic [2:0]  exp_count;
    logic [15:0] exp_digits;
  } press_t;

  press_t     tbl[8];
  logic [3:0] sb_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int kv_cnt = 0;
  int cr_cnt = 0;
  int to_cnt = 0;
  int mk_cnt = 0;
  int n_pushed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (o_key_valid === 1'b1) begin
      kv_cnt++;
      if (sb_q.size() == 0) begin
        check("kv_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_digit", 32'(o_digits[3:0]), 32'(e));
      end
    end
    if (o_code_ready === 1'b1) cr_cnt++;
    if (o_timeout === 1'b1) to_cnt++;
    if (o_multi_key_err === 1'b1) mk_cnt++;
  endtask

  task automatic expect_key(input int key);
    sb_q.push_back(4'(key));
    n_pushed++;
  endtask

  task automatic press(input int key, input int hold, input int gap, input bit accept);
    if (accept) expect_key(key);
    keypad = 10'd1 << key;
    repeat (hold) tick();
    keypad = 10'd0;
    repeat (gap) tick();
  endtask

  task automatic run_table(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      press(tbl[i].key, tbl[i].hold, tbl[i].gap, tbl[i].accept);
      check("tbl_count", 32'(o_digit_count), 32'(tbl[i].exp_count));
      check("tbl_digits", 32'(o_digits), 32'(tbl[i].exp_digits));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 5, 2, 1'b1, 3'd1, 16'h0001};
    tbl[1] = '{9, 5, 2, 1'b1, 3'd2, 16'h0019};
    tbl[2] = '{0, 5, 2, 1'b1, 3'd3, 16'h0190};
    tbl[3] = '{7, 5, 2, 1'b1, 3'd4, 16'h1907};
    tbl[4] = '{1, 5, 2, 1'b1, 3'd1, 16'h0001};
    tbl[5] = '{2, 5, 2, 1'b1, 3'd2, 16'h0012};
    tbl[6] = '{3, 5, 2, 1'b1, 3'd3, 16'h0123};
    tbl[7] = '{4, 5, 2, 1'b1, 3'd4, 16'h1234};

    // Reset with a key held
    clear = 1'b1; keypad = 10'b0000000001; enter = 1'b0; cancel = 1'b0;
    repeat (3) tick();
    check("rst_digits", 32'(o_digits), 32'd0);
    check("rst_count", 32'(o_digit_count), 32'd0);
    check("rst_kv", 32'(o_key_valid), 32'd0);
    check("rst_cr", 32'(o_code_ready), 32'd0);
    check("rst_to", 32'(o_timeout), 32'd0);
    check("rst_mk", 32'(o_multi_key_err), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_kv_cnt", 32'(kv_cnt), 32'd0);
    clear = 1'b0; keypad = 10'd0;
    repeat (2) tick();
    press(0, 5, 2, 1'b1);
    check("rst_repress_count", 32'(o_digit_count), 32'd1);
    check("rst_repress_kv", 32'(kv_cnt), 32'd1);
    cancel = 1'b1; tick(); cancel = 1'b0;
    check("cancel_count", 32'(o_digit_count), 32'd0);

    // Entry and commit
    run_table(0, 3);
    check("entry_kv", 32'(kv_cnt), 32'(n_pushed));
    enter = 1'b1; tick(); enter = 1'b0;
    check("commit_cr", 32'(o_code_ready), 32'd1);
    check("commit_count", 32'(o_digit_count), 32'd0);
    tick();
    check("commit_cr_off", 32'(o_code_ready), 32'd0);
    check("commit_digits", 32'(o_digits), 32'h1907);
    check("commit_cr_cnt", 32'(cr_cnt), 32'd1);

    // Short bounce, then a long hold yields one digit on the cycle after the 3rd edge
    keypad = 10'd1 << 5; tick(); tick();
    keypad = 10'd0; tick(); tick();
    check("bounce_kv", 32'(kv_cnt), 32'(n_pushed));
    check("bounce_busy", 32'(o_busy), 32'd0);
    expect_key(5);
    keypad = 10'd1 << 5;
    tick(); check("hold_e1_kv", 32'(o_key_valid), 32'd0);
    check("hold_e1_busy", 32'(o_busy), 32'd1);
    tick(); check("hold_e2_kv", 32'(o_key_valid), 32'd0);
    tick(); check("hold_e3_kv", 32'(o_key_valid), 32'd1);
    check("hold_count", 32'(o_digit_count), 32'd1);
    check("hold_digits", 32'(o_digits), 32'h0005);
    repeat (37) tick();
    check("hold_once", 32'(kv_cnt), 32'(n_pushed));
    keypad = 10'd0; tick();
    check("hold_release_busy", 32'(o_busy), 32'd0);
    tick();

    // Multi-key
    keypad = 10'b0000000110; tick();
    check("mk_pulse", 32'(o_multi_key_err), 32'd1);
    check("mk_count", 32'(o_digit_count), 32'd1);
    tick();
    check("mk_pulse_off", 32'(o_multi_key_err), 32'd0);
    keypad = 10'b0000000100;
    repeat (6) tick();
    check("mk_no_accept", 32'(kv_cnt), 32'(n_pushed));
    keypad = 10'd0; repeat (2) tick();
    press(2, 5, 2, 1'b1);
    check("mk_after_count", 32'(o_digit_count), 32'd2);
    check("mk_after_digits", 32'(o_digits), 32'h0052);
    check("mk_cnt", 32'(mk_cnt), 32'd1);

    // Timeout on the 20th idle edge
    cancel = 1'b1; tick(); cancel = 1'b0;
    check("cancel2_digits", 32'(o_digits), 32'd0);
    expect_key(3);
    keypad = 10'd1 << 3; repeat (5) tick();
    keypad = 10'd0; tick();
    check("to_busy", 32'(o_busy), 32'd0);
    check("to_start_count", 32'(o_digit_count), 32'd1);
    repeat (19) tick();
    check("to_early", 32'(to_cnt), 32'd0);
    tick();
    check("to_pulse", 32'(o_timeout), 32'd1);
    check("to_count", 32'(o_digit_count), 32'd0);
    check("to_digits", 32'(o_digits), 32'd0);
    tick();
    check("to_pulse_off", 32'(o_timeout), 32'd0);

    // Full buffer never times out
    run_table(4, 7);
    repeat (100) tick();
    check("full_no_to", 32'(to_cnt), 32'd1);
    check("full_count", 32'(o_digit_count), 32'd4);

    // Fifth key while full is dropped
    press(8, 5, 2, 1'b0);
    check("full_kv", 32'(kv_cnt), 32'(n_pushed));
    check("full_digits", 32'(o_digits), 32'h1234);
    enter = 1'b1; tick(); enter = 1'b0;
    check("full_commit_cr", 32'(o_code_ready), 32'd1);
    press(6, 5, 2, 1'b1);
    check("after_commit_digits", 32'(o_digits), 32'h0006);

    // Cancel on the accepting edge
    keypad = 10'd1 << 7; tick(); tick();
    cancel = 1'b1; tick(); cancel = 1'b0;
    check("cancel_db_kv", 32'(o_key_valid), 32'd0);
    check("cancel_db_count", 32'(o_digit_count), 32'd0);
    check("cancel_db_digits", 32'(o_digits), 32'd0);
    check("cancel_db_busy", 32'(o_busy), 32'd1);
    repeat (3) tick();
    keypad = 10'd0; repeat (2) tick();
    check("cancel_db_total", 32'(kv_cnt), 32'(n_pushed));

    // Enter with a partial entry does nothing
    press(1, 5, 2, 1'b1);
    press(2, 5, 2, 1'b1);
    enter = 1'b1; tick(); enter = 1'b0;
    check("partial_enter_cr", 32'(o_code_ready), 32'd0);
    check("partial_enter_count", 32'(o_digit_count), 32'd2);
    check("partial_enter_digits", 32'(o_digits), 32'h0012);
    check("cr_total", 32'(cr_cnt), 32'd2);

    // Clear in the middle of debounce
    keypad = 10'd1 << 4; tick(); tick();
    clear = 1'b1; tick();
    check("clr_db_busy", 32'(o_busy), 32'd0);
    check("clr_db_count", 32'(o_digit_count), 32'd0);
    check("clr_db_digits", 32'(o_digits), 32'd0);
    clear = 1'b0; keypad = 10'd0; repeat (2) tick();
    check("final_kv", 32'(kv_cnt), 32'(n_pushed));
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Sequencing controller for the input-control path.
- Samples the 10-line one-hot keypad, debounces it and enforces one digit per press (non-repeating).
- Assembles NUM_DIGITS BCD digits into an entry register and releases them on `enter`.
- Sits between the raw keypad and the downstream code-compare/config logic; handles cancel, inactivity timeout and multi-key errors.

Parameters:
- NUM_DIGITS, 4, digits per code; digits width = 4*NUM_DIGITS; range 1..7.
- STABLE_CYCLES, 3, consecutive identical samples required to accept a key; range >=1.
- TIMEOUT_CYCLES, 70, idle cycles with a partial entry before it is discarded; range >=2.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  synchronous reset, active high.
- keypad  in  10  key lines; bit i high = digit i pressed.
- enter  in  1  commit request; level, sampled each edge.
- cancel  in  1  abort entry; level, sampled each edge.
- digits  out  4*NUM_DIGITS  entry buffer; newest digit in [3:0].
- digit_count  out  3  digits currently held, 0..NUM_DIGITS.
- key_valid  out  1  one-cycle pulse, digit accepted.
- code_ready  out  1  one-cycle pulse, full code committed.
- timeout  out  1  one-cycle pulse, partial entry discarded.
- multi_key_err  out  1  one-cycle pulse, more than one key seen.
- busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Reset: `clear` high at an edge drives every output and counter to 0 and the FSM to IDLE. It overrides everything, including mid-debounce and mid-hold.
- Priority per edge: clear > cancel > enter > keypad FSM > timeout.
- FSM states: IDLE, DEBOUNCE, HOLD.
- IDLE, keypad==0: stay in IDLE.
- IDLE, exactly one bit set: latch the pattern, set stable_cnt=1, go to DEBOUNCE. If STABLE_CYCLES==1, accept immediately and go to HOLD.
- IDLE, two or more bits set: pulse multi_key_err next cycle, go to HOLD; no digit is stored.
- DEBOUNCE, keypad equals the latched pattern: stable_cnt++. When it reaches STABLE_CYCLES, accept the digit and go to HOLD.
- DEBOUNCE, keypad differs (including release): return to IDLE silently.
- HOLD: stay until keypad==0, then IDLE. A key held indefinitely therefore yields exactly one digit.
- Accept timing: the key is seen on edges e1..eN (N=STABLE_CYCLES). At eN the digit is written, digit_count increments, and key_valid is high for the cycle following eN.
- Digit encode: one-hot index 0..9 becomes a 4-bit BCD value.
- Digit write when digit_count==0: digits <= {0, code}.
- Digit write otherwise: digits <= {digits[4*NUM_DIGITS-5:0], code}.
- Full buffer: if digit_count==NUM_DIGITS, further accepted presses are discarded. There is no key_valid pulse and digits are unchanged; the FSM still passes through HOLD.
- enter with digit_count==NUM_DIGITS: code_ready pulses 1 cycle and digit_count becomes 0. digits stays stable until the next accepted digit, cancel, timeout or clear.
- enter with digit_count<NUM_DIGITS: no effect.
- cancel: digits=0 and digit_count=0. FSM goes to HOLD if keypad!=0, else IDLE. No pulses.
- Collisions: if enter or cancel acts on the same edge as a key accept, the key is discarded and the FSM goes to HOLD.
- Timeout counter, counting: increments each edge while 0<digit_count<NUM_DIGITS and FSM==IDLE.
- Timeout counter, zeroing: zeroed on any accepted digit, enter, cancel, or when FSM!=IDLE.
- Timeout expiry: on the edge where the counter reaches TIMEOUT_CYCLES, timeout pulses 1 cycle, digits=0, digit_count=0 and the counter is zeroed.
- Full buffer and timeout: a full buffer never times out; it waits for enter or cancel.
- busy = (state != IDLE).
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
Parameters for all scenarios: STABLE_CYCLES=3, TIMEOUT_CYCLES=20, NUM_DIGITS=4.
1. Reset: pulse clear with keypad=10'b0000000001 held -> all outputs 0, then exactly one key_valid after release and re-press; with keypad still held, no digit.
2. Entry and commit: presses 1,9,0,7, each held 5 cycles with 2-cycle gaps, then enter -> four key_valid pulses; digit_count 1..4; digits=16'h1907; code_ready 1 cycle; digit_count=0, digits still 16'h1907.
3. Debounce and hold: key 5 for 2 cycles -> nothing. Key 5 for 40 cycles -> exactly one key_valid, on the cycle after the 3rd sampled edge.
4. Multi-key: keypad=10'b0000000110 -> multi_key_err 1 cycle, digit_count unchanged. A new key is accepted only after keypad returns to 0.
5. Timeout: press 3, then idle 20 cycles -> timeout pulse on the 20th idle edge; digits=0, digit_count=0. Full buffer idle 100 cycles -> no timeout.
6. Collisions: 5th key while full -> no key_valid. cancel during DEBOUNCE -> count 0, no accept. enter with count 2 -> no code_ready.
